// File: rtl/ne_fp_ffp_norm_mwi27.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ne_fp_ffp_norm_mwi27 : FFP adder post-stage (renormalize, RNE round, pack)
// Rev 1.0
// ---------------------------------------------------------------------------
module ne_fp_ffp_norm_mwi27 #(
  parameter int EWI       = 10,
  parameter int MWI_IN    = 27,
  parameter int MWO       = 26,
  parameter int BW_STATUS = 3,
  parameter int CNT_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_vld,
  output logic                              in_rdy,
  input  logic [BW_STATUS+EWI+MWI_IN:0]     in_data,
  input  logic [2:0]                        in_mode,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic [BW_STATUS+EWI+MWO:0]        out_data,
  output logic [2:0]                        out_mode,
  input  logic                              cnt_clr,
  output logic [CNT_W-1:0]                  ovf_cnt,
  output logic [CNT_W-1:0]                  udf_cnt
);

  localparam int EW = EWI + 1;
  localparam int LW = $clog2(MWI_IN);
  localparam int OW = BW_STATUS + 1 + EWI + MWO;

  localparam logic [EWI-1:0]       C_EXP_ZERO = EWI'(10'h381);
  localparam logic [EWI-1:0]       C_EXP_INF  = EWI'(10'h080);
  localparam logic signed [EW-1:0] C_EMIN     = EW'(-126);
  localparam logic signed [EW-1:0] C_EMAX     = EW'(127);
  localparam logic [MWO-1:0]       C_POS_MAX  = {1'b0, {(MWO-1){1'b1}}};
  localparam logic [MWO-1:0]       C_M_ONE    = {2'b01, {(MWO-2){1'b0}}};

  // Input field split
  logic [MWI_IN-1:0]    in_m;
  logic [EWI-1:0]       in_e;
  logic                 in_s;
  logic [BW_STATUS-1:0] in_st;

  assign in_m  = in_data[MWI_IN-1:0];
  assign in_e  = in_data[MWI_IN+EWI-1:MWI_IN];
  assign in_s  = in_data[MWI_IN+EWI];
  assign in_st = in_data[BW_STATUS+EWI+MWI_IN -: BW_STATUS];

  // Stage registers
  logic                 s1_v_q, s2_v_q;
  logic [2:0]           s1_mode_q, s2_mode_q;
  logic [OW-1:0]        s1_raw_q;
  logic [BW_STATUS-1:0] s1_st_q;
  logic                 s1_s_q, s1_zero_q;
  logic [MWI_IN-1:0]    s1_m_q, s1_m_d;
  logic [EW-1:0]        s1_e_q, s1_e_d;
  logic [OW-1:0]        s2_data_q, s2_data_d;
  logic                 s2_ovf_q, s2_ovf_d, s2_udf_q, s2_udf_d;
  logic [CNT_W-1:0]     ovf_q, ovf_d, udf_q, udf_d;

  logic s2_load;

  assign s2_load = ~s2_v_q | out_rdy;
  assign in_rdy  = ~s1_v_q | ~s2_v_q | out_rdy;

  // Leading-sign count: highest bit position that differs from its upper neighbour
  logic [LW-1:0] lsc;
  always_comb begin
    lsc = LW'(MWI_IN-1);
    for (int i = 0; i < MWI_IN-1; i++) begin
      if (in_m[i] ^ in_m[i+1]) lsc = LW'(MWI_IN-2-i);
    end
  end

  assign s1_m_d = in_m << lsc;
  assign s1_e_d = {in_e[EWI-1], in_e} - EW'(lsc);

  // Stage 2: round-to-nearest-even, exponent range check, encoding
  logic [MWO-1:0]       kept, m_rnd;
  logic                 rnd, carry, sgn;
  logic signed [EW-1:0] exp_r;

  always_comb begin
    kept      = s1_m_q[MWI_IN-1:1];
    rnd       = s1_m_q[0] & s1_m_q[1];
    carry     = rnd & (kept == C_POS_MAX);
    m_rnd     = carry ? C_M_ONE : kept + MWO'(rnd);
    exp_r     = s1_e_q + {{(EW-1){1'b0}}, carry};
    sgn       = s1_m_q[MWI_IN-1];
    s2_ovf_d  = 1'b0;
    s2_udf_d  = 1'b0;
    s2_data_d = {{BW_STATUS{1'b0}}, m_rnd[MWO-1], exp_r[EWI-1:0], m_rnd};
    if (s1_mode_q[0]) begin
      s2_data_d = s1_raw_q;
    end else if (s1_st_q[2]) begin
      s2_data_d = {3'b100, s1_s_q, C_EXP_INF, s1_s_q, s1_s_q, 1'b1, {(MWO-3){1'b0}}};
    end else if (s1_st_q[1]) begin
      s2_data_d = {3'b010, s1_s_q, C_EXP_INF, s1_s_q, s1_s_q, {(MWO-2){1'b0}}};
    end else if (s1_st_q[0]) begin
      s2_data_d = {3'b001, s1_s_q, C_EXP_ZERO, {MWO{1'b0}}};
    end else if (s1_zero_q) begin
      s2_data_d = {3'b001, 1'b0, C_EXP_ZERO, {MWO{1'b0}}};
    end else if (exp_r < C_EMIN) begin
      s2_data_d = {3'b001, 1'b0, C_EXP_ZERO, {MWO{1'b0}}};
      s2_udf_d  = 1'b1;
    end else if (exp_r > C_EMAX) begin
      s2_data_d = {3'b010, sgn, C_EXP_INF, sgn, sgn, {(MWO-2){1'b0}}};
      s2_ovf_d  = 1'b1;
    end
  end

  // Event counters: clear wins over a same-cycle delivery, saturate at all-ones
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (cnt_clr) begin
      ovf_d = '0;
      udf_d = '0;
    end else if (s2_v_q & out_rdy) begin
      if (s2_ovf_q && !(&ovf_q)) ovf_d = ovf_q + CNT_W'(1);
      if (s2_udf_q && !(&udf_q)) udf_d = udf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_mode_q <= '0;
      s1_raw_q  <= '0;
      s1_st_q   <= '0;
      s1_s_q    <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_m_q    <= '0;
      s1_e_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_mode_q <= '0;
      s2_data_q <= '0;
      s2_ovf_q  <= 1'b0;
      s2_udf_q  <= 1'b0;
      ovf_q     <= '0;
      udf_q     <= '0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      if (s2_load) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_mode_q <= s1_mode_q;
          s2_data_q <= s2_data_d;
          s2_ovf_q  <= s2_ovf_d;
          s2_udf_q  <= s2_udf_d;
        end
      end
      if (in_rdy) begin
        s1_v_q <= in_vld;
        if (in_vld) begin
          s1_mode_q <= in_mode;
          s1_raw_q  <= in_data[OW-1:0];
          s1_st_q   <= in_st;
          s1_s_q    <= in_s;
          s1_zero_q <= (in_m == '0);
          s1_m_q    <= s1_m_d;
          s1_e_q    <= s1_e_d;
        end
      end
    end
  end

  assign out_vld  = s2_v_q;
  assign out_data = s2_data_q;
  assign out_mode = s2_mode_q;
  assign ovf_cnt  = ovf_q;
  assign udf_cnt  = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_ne_fp_ffp_norm_mwi27.sv
`default_nettype none
// Scoreboard bench for ne_fp_ffp_norm_mwi27: directed corner beats plus
// randomized beats checked against an arithmetic reference model.
module tb_ne_fp_ffp_norm_mwi27;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld, in_rdy;
  logic [40:0] in_data;
  logic [2:0]  in_mode;
  logic        out_vld, out_rdy;
  logic [39:0] out_data;
  logic [2:0]  out_mode;
  logic        cnt_clr;
  logic [15:0] ovf_cnt, udf_cnt;

  ne_fp_ffp_norm_mwi27 dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_mode(in_mode),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_mode(out_mode),
    .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [39:0] d;
    logic [2:0]  mode;
    bit          ovf;
    bit          udf;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int   exp_ovf = 0, exp_udf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [40:0] mk_in(input logic [2:0] st, input logic s,
                                        input logic [9:0] e, input logic [26:0] m);
    return {st, s, e, m};
  endfunction

  function automatic logic [39:0] pk(input logic [2:0] st, input logic s,
                                     input logic [9:0] e, input logic [25:0] m);
    return {st, s, e, m};
  endfunction

  // Reference: shift until the top two bits differ, then value-level rounding
  task automatic ref_model(input logic [40:0] d, input logic [2:0] md,
                           output logic [39:0] od, output bit ov, output bit ud);
    logic [2:0]  st;
    logic        s;
    logic [26:0] x;
    int          ex, l, mv, q;
    st = d[40:38];
    s  = d[37];
    x  = d[26:0];
    ex = int'($signed(d[36:27]));
    ov = 0;
    ud = 0;
    if (md[0])            od = d[39:0];
    else if (st[2])       od = pk(3'b100, s, 10'h080, {s, s, 1'b1, 23'b0});
    else if (st[1])       od = pk(3'b010, s, 10'h080, {s, s, 24'b0});
    else if (st[0])       od = pk(3'b001, s, 10'h381, 26'b0);
    else if (x == 27'd0)  od = pk(3'b001, 1'b0, 10'h381, 26'b0);
    else begin
      l = 0;
      while (l < 26 && x[26] == x[25]) begin
        x = x << 1;
        l++;
      end
      ex = ex - l;
      mv = int'($signed(x));
      q  = mv >>> 1;
      if ((mv & 1) != 0 && (q & 1) != 0) q = q + 1;
      if (q == (1 << 25)) begin
        q  = 1 << 24;
        ex = ex + 1;
      end
      if (ex < -126) begin
        od = pk(3'b001, 1'b0, 10'h381, 26'b0);
        ud = 1;
      end else if (ex > 127) begin
        od = pk(3'b010, d[26], 10'h080, {d[26], d[26], 24'b0});
        ov = 1;
      end else begin
        od = pk(3'b000, q[25], ex[9:0], q[25:0]);
      end
    end
  endtask

  task automatic push_exp(input logic [39:0] ed, input logic [2:0] md, input bit ov, input bit ud);
    exp_t x;
    x.d = ed; x.mode = md; x.ovf = ov; x.udf = ud;
    sb.push_back(x);
  endtask

  task automatic push_model(input logic [40:0] d, input logic [2:0] md);
    logic [39:0] ed;
    bit ov, ud;
    ref_model(d, md, ed, ov, ud);
    push_exp(ed, md, ov, ud);
  endtask

  // Called just after a rising edge; returns just after a rising edge
  task automatic send_exp(input logic [40:0] d, input logic [2:0] md,
                          input logic [39:0] ed, input bit ov, input bit ud);
    int n = 0;
    in_vld = 1; in_data = d; in_mode = md;
    forever begin
      @(negedge clk);
      if (in_rdy) break;
      n++;
      if (n > 200) begin
        chk("in_rdy_timeout", {63'd0, in_rdy}, 64'd1);
        break;
      end
      @(posedge clk); #1;
    end
    if (in_rdy) push_exp(ed, md, ov, ud);
    @(posedge clk); #1;
    in_vld = 0;
  endtask

  task automatic send_model(input logic [40:0] d, input logic [2:0] md);
    logic [39:0] ed;
    bit ov, ud;
    ref_model(d, md, ed, ov, ud);
    send_exp(d, md, ed, ov, ud);
  endtask

  task automatic rand_beat(output logic [40:0] d, output logic [2:0] md);
    logic [26:0] m;
    logic [2:0]  st;
    int r;
    m = 27'($urandom);
    m = 27'($signed(m) >>> $urandom_range(0, 26));
    r = $urandom_range(0, 99);
    if (r < 5)       m = 27'd0;
    else if (r < 8)  m = '1;
    else if (r < 11) m = 27'h3FFFFFF;
    r = $urandom_range(0, 19);
    st = (r == 0) ? 3'b100 : (r == 1) ? 3'b010 : (r == 2) ? 3'b001 :
         (r == 3) ? 3'($urandom) : 3'b000;
    d = mk_in(st, 1'($urandom), 10'(int'($urandom_range(0, 300)) - 150), m);
    r = $urandom_range(0, 9);
    md = (r == 0) ? 3'b001 : (r < 6) ? 3'b100 : 3'b010;
  endtask

  task automatic drain;
    int n = 0;
    rdy_mode = 1;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // out_rdy driver
  initial begin
    out_rdy = 1;
    forever begin
      @(posedge clk); #1;
      out_rdy = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    end
  end

  // Monitor: pops the scoreboard on every delivered beat, tracks counters and holds
  exp_t        mon_e;
  bit          stall_prev = 0;
  logic [39:0] prev_data;
  bit          pend_ovf, pend_udf;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        exp_ovf = 0;
        exp_udf = 0;
        stall_prev = 0;
      end else begin
        pend_ovf = 0;
        pend_udf = 0;
        if (stall_prev) begin
          chk("hold_vld", {63'd0, out_vld}, 64'd1);
          chk("hold_data", 64'(out_data), 64'(prev_data));
        end
        chk("ovf_cnt", 64'(ovf_cnt), 64'(exp_ovf));
        chk("udf_cnt", 64'(udf_cnt), 64'(exp_udf));
        if (out_vld && out_rdy) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", {63'd0, out_vld}, 64'd0);
          end else begin
            mon_e = sb.pop_front();
            chk("out_data", 64'(out_data), 64'(mon_e.d));
            chk("out_mode", 64'(out_mode), 64'(mon_e.mode));
            pend_ovf = mon_e.ovf;
            pend_udf = mon_e.udf;
          end
        end
        if (cnt_clr) begin
          exp_ovf = 0;
          exp_udf = 0;
        end else begin
          if (pend_ovf && exp_ovf < 65535) exp_ovf++;
          if (pend_udf && exp_udf < 65535) exp_udf++;
        end
        stall_prev = out_vld && !out_rdy;
        prev_data  = out_data;
      end
    end
  end

  logic [40:0] bd [4];
  logic [2:0]  bm [4];
  logic [40:0] rd;
  logic [2:0]  rm;
  int          idx;

  initial begin
    rst = 1; in_vld = 0; in_data = '0; in_mode = '0; cnt_clr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
    chk("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_mode", 64'(out_mode), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);
    chk("rst_udf", 64'(udf_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Directed corner beats with hand-derived expectations
    send_exp(mk_in(3'b000, 1'b0, 10'd5, 27'h0800000), 3'b100,
             pk(3'b000, 1'b0, 10'h003, 26'h1000000), 0, 0);
    send_exp(mk_in(3'b000, 1'b0, 10'd0, 27'h2000003), 3'b010,
             pk(3'b000, 1'b0, 10'h000, 26'h1000002), 0, 0);
    send_exp(mk_in(3'b000, 1'b0, 10'd0, 27'h3FFFFFF), 3'b100,
             pk(3'b000, 1'b0, 10'h001, 26'h1000000), 0, 0);
    send_exp(mk_in(3'b000, 1'b0, 10'h382, 27'h0800000), 3'b100,
             pk(3'b001, 1'b0, 10'h381, 26'h0), 0, 1);
    send_exp(mk_in(3'b000, 1'b0, 10'd127, 27'h3FFFFFF), 3'b100,
             pk(3'b010, 1'b0, 10'h080, 26'h0), 1, 0);
    send_exp(mk_in(3'b100, 1'b1, 10'h055, 27'h1234567), 3'b100,
             pk(3'b100, 1'b1, 10'h080, 26'h3800000), 0, 0);
    send_exp(mk_in(3'b000, 1'b0, 10'd30, 27'h7FFFFFF), 3'b010,
             pk(3'b000, 1'b1, 10'h004, 26'h2000000), 0, 0);
    send_exp(mk_in(3'b000, 1'b0, 10'd0, 27'h4000000), 3'b100,
             pk(3'b000, 1'b1, 10'h000, 26'h2000000), 0, 0);
    send_exp(mk_in(3'b000, 1'b1, 10'd7, 27'h0), 3'b100,
             pk(3'b001, 1'b0, 10'h381, 26'h0), 0, 0);
    rd = mk_in(3'b101, 1'b1, 10'h2AB, 27'h5A5A5A5);
    send_exp(rd, 3'b001, rd[39:0], 0, 0);
    drain();

    @(posedge clk); #1; cnt_clr = 1;
    @(posedge clk); #1; cnt_clr = 0;

    // Randomized traffic with random backpressure and idle gaps
    rdy_mode = 2;
    for (int k = 0; k < 300; k++) begin
      rand_beat(rd, rm);
      send_model(rd, rm);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    // Stall: only two beats fit while out_rdy is low
    rdy_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 0; k < 4; k++) begin
      rand_beat(bd[k], bm[k]);
    end
    idx = 0;
    in_vld = 1; in_data = bd[0]; in_mode = bm[0];
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (in_rdy && idx < 4) begin push_model(bd[idx], bm[idx]); idx++; end
      @(posedge clk); #1;
      if (idx < 4) begin in_data = bd[idx]; in_mode = bm[idx]; end
    end
    chk("stall_accepted", 64'(idx), 64'd2);
    @(negedge clk);
    chk("stall_in_rdy", {63'd0, in_rdy}, 64'd0);
    @(posedge clk); #1;
    rdy_mode = 1;
    for (int k = 0; k < 50 && idx < 4; k++) begin
      @(negedge clk);
      if (in_rdy && idx < 4) begin push_model(bd[idx], bm[idx]); idx++; end
      @(posedge clk); #1;
      if (idx < 4) begin in_data = bd[idx]; in_mode = bm[idx]; end
    end
    in_vld = 0;
    chk("stall_all_accepted", 64'(idx), 64'd4);
    drain();

    // Reset with two beats in flight
    rdy_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    send_exp(mk_in(3'b000, 1'b0, 10'd200, 27'h3FFFFFF), 3'b100,
             pk(3'b010, 1'b0, 10'h080, 26'h0), 1, 0);
    send_exp(mk_in(3'b000, 1'b0, 10'd3, 27'h0100000), 3'b100,
             pk(3'b000, 1'b0, 10'h3FE, 26'h1000000), 0, 0);
    chk("pre_rst_out_vld", {63'd0, out_vld}, 64'd1);
    #3 rst = 1;
    #1;
    chk("async_rst_out_vld", {63'd0, out_vld}, 64'd0);
    chk("async_rst_ovf", 64'(ovf_cnt), 64'd0);
    chk("async_rst_udf", 64'(udf_cnt), 64'd0);
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("post_rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_output", {63'd0, out_vld}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
